// File: rtl/inst_encoder_if.sv
// Field-bundle input handshake plus instruction-memory write port for inst_encoder.
// The master side is the program loader and the memory model. The slave side is the encoder.
interface inst_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [4:0]            rs_addr;
  logic [4:0]            rt_addr;
  logic [4:0]            rd_addr;
  logic [15:0]           immediate_constant;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  imem_ready;

  modport master (
    output in_valid, op, rs_addr, rt_addr, rd_addr, immediate_constant, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, op, rs_addr, rt_addr, rd_addr, immediate_constant, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded MIPS fields into 32-bit words and streams them into instruction memory,
// tracking the load address, the fill level and a sticky illegal-op flag.
module inst_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  inst_encoder_if.slave         bus,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_full,
  output logic                  o_bad_op
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PEND  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0]   LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [31:0]           r_wdata;
  logic                  r_bad_op;

  logic        w_write;
  logic        w_last;
  logic        w_accept;
  logic        w_legal;
  logic [31:0] w_enc;

  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    logic [31:0] word;
    word = 32'h0;
    case (op)
      3'd0:    word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      3'd1:    word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      3'd2:    word = {6'h23, rs, rt, imm};
      3'd3:    word = {6'h2B, rs, rt, imm};
      3'd4:    word = {6'h08, rs, rt, imm};
      3'd5:    word = {6'h04, rs, rt, imm};
      default: word = 32'h0;
    endcase
    return word;
  endfunction

  assign w_enc    = encode(bus.op, bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.immediate_constant);
  assign w_legal  = !(bus.op[2] && bus.op[1]);
  assign w_write  = (r_state == S_PEND) && bus.imem_ready;
  // The write that fills the last slot must not let a new bundle in.
  assign w_last   = (r_count == LAST);
  assign w_accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready   = (r_state == S_EMPTY) ||
                          ((r_state == S_PEND) && bus.imem_ready && !w_last);
  assign bus.imem_we    = (r_state == S_PEND);
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign o_word_count   = r_count;
  assign o_full         = (r_state == S_FULL);
  assign o_bad_op       = r_bad_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_addr   <= BASE;
      r_count  <= '0;
      r_wdata  <= 32'h0;
      r_bad_op <= 1'b0;
    end else if (i_clear) begin
      r_state  <= S_EMPTY;
      r_addr   <= BASE;
      r_count  <= '0;
      r_wdata  <= 32'h0;
      r_bad_op <= 1'b0;
    end else begin
      if (w_write) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count + 1'b1;
      end
      if (w_accept && !w_legal) begin
        r_bad_op <= 1'b1;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_accept && w_legal) begin
            r_state <= S_PEND;
            r_wdata <= w_enc;
          end
        end
        S_PEND: begin
          if (w_write) begin
            if (w_last) begin
              r_state <= S_FULL;
            end else if (w_accept && w_legal) begin
              r_wdata <= w_enc;
            end else begin
              r_state <= S_EMPTY;
            end
          end
        end
        S_FULL: begin
          r_state <= S_FULL;
        end
        default: begin
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a default-size instance plus two 4-word instances
// (base 0 and base 3) for the fill and address-wrap cases.
module tb_inst_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clearA = 1'b0;
  logic clearB = 1'b0;
  logic clearC = 1'b0;

  int total = 0;
  int bad   = 0;

  inst_encoder_if #(.ADDR_WIDTH(8)) busA ();
  inst_encoder_if #(.ADDR_WIDTH(2)) busB ();
  inst_encoder_if #(.ADDR_WIDTH(2)) busC ();

  logic [8:0] countA;
  logic       fullA;
  logic       badA;
  logic [2:0] countB;
  logic       fullB;
  logic       badB;
  logic [2:0] countC;
  logic       fullC;
  logic       badC;

  inst_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dutA (
    .clk(clk), .rst(rst), .i_clear(clearA), .bus(busA.slave),
    .o_word_count(countA), .o_full(fullA), .o_bad_op(badA)
  );

  inst_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dutB (
    .clk(clk), .rst(rst), .i_clear(clearB), .bus(busB.slave),
    .o_word_count(countB), .o_full(fullB), .o_bad_op(badB)
  );

  inst_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(3)) dutC (
    .clk(clk), .rst(rst), .i_clear(clearC), .bus(busC.slave),
    .o_word_count(countC), .o_full(fullC), .o_bad_op(badC)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
    busA.in_valid           = v;
    busA.op                 = op;
    busA.rs_addr            = rs;
    busA.rt_addr            = rt;
    busA.rd_addr            = rd;
    busA.immediate_constant = imm;
  endtask

  // Same addi bundle (rt = imm = k) to both small instances.
  task automatic driveSmall(input logic v, input int k);
    busB.in_valid = v; busB.op = 3'd4; busB.rs_addr = 5'd0; busB.rd_addr = 5'd0;
    busB.rt_addr = 5'(k); busB.immediate_constant = 16'(k);
    busC.in_valid = v; busC.op = 3'd4; busC.rs_addr = 5'd0; busC.rd_addr = 5'd0;
    busC.rt_addr = 5'(k); busC.immediate_constant = 16'(k);
  endtask

  task automatic pulseClearA();
    clearA = 1'b1;
    step();
    clearA = 1'b0;
  endtask

  initial begin
    logic [31:0] expWord;
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    busA.imem_ready = 1'b0;
    busB.imem_ready = 1'b0;
    busC.imem_ready = 1'b0;
    driveSmall(1'b0, 0);
    step();
    step();

    $display("[TB] reset values");
    checkOutput("rst_in_ready", busA.in_ready, 1);
    checkOutput("rst_we", busA.imem_we, 0);
    checkOutput("rst_addr", busA.imem_addr, 0);
    checkOutput("rst_wdata", busA.imem_wdata, 0);
    checkOutput("rst_count", countA, 0);
    checkOutput("rst_full", fullA, 0);
    checkOutput("rst_bad", badA, 0);
    checkOutput("rst_addrC", busC.imem_addr, 3);
    rst = 1'b0;

    $display("[TB] single add");
    busA.imem_ready = 1'b1;
    applyStimulus(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF);
    #1 checkOutput("t1_in_ready", busA.in_ready, 1);
    step();
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    #1;
    checkOutput("t1_we", busA.imem_we, 1);
    checkOutput("t1_addr", busA.imem_addr, 0);
    checkOutput("t1_wdata", busA.imem_wdata, 32'h00221820);
    step();
    checkOutput("t1_we_after", busA.imem_we, 0);
    checkOutput("t1_count", countA, 1);
    checkOutput("t1_addr_after", busA.imem_addr, 1);

    pulseClearA();
    #1;
    checkOutput("clr_addr", busA.imem_addr, 0);
    checkOutput("clr_count", countA, 0);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 3'd2, 5'd4, 5'd5, 5'd31, 16'h0010);
    step();
    applyStimulus(1'b1, 3'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF);
    #1;
    checkOutput("b2b_lw_wdata", busA.imem_wdata, 32'h8C850010);
    checkOutput("b2b_lw_addr", busA.imem_addr, 0);
    checkOutput("b2b_rdy0", busA.in_ready, 1);
    step();
    applyStimulus(1'b1, 3'd4, 5'd0, 5'd8, 5'd0, 16'h0005);
    #1;
    checkOutput("b2b_beq_wdata", busA.imem_wdata, 32'h1022FFFF);
    checkOutput("b2b_beq_addr", busA.imem_addr, 1);
    checkOutput("b2b_rdy1", busA.in_ready, 1);
    step();
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    #1;
    checkOutput("b2b_addi_wdata", busA.imem_wdata, 32'h20080005);
    checkOutput("b2b_addi_addr", busA.imem_addr, 2);
    checkOutput("b2b_addi_we", busA.imem_we, 1);
    step();
    checkOutput("b2b_count", countA, 3);
    checkOutput("b2b_we_done", busA.imem_we, 0);

    $display("[TB] back-pressure");
    pulseClearA();
    busA.imem_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 5'd7, 5'd8, 5'd9, 16'h1234);
    step();
    applyStimulus(1'b1, 3'd0, 5'd1, 5'd1, 5'd1, 16'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp_wdata%0d", i), busA.imem_wdata, 32'h00E8482A);
      checkOutput($sformatf("bp_addr%0d", i), busA.imem_addr, 0);
      checkOutput($sformatf("bp_rdy%0d", i), busA.in_ready, 0);
      step();
    end
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    busA.imem_ready = 1'b1;
    #1 checkOutput("bp_rdy_release", busA.in_ready, 1);
    step();
    checkOutput("bp_count", countA, 1);
    checkOutput("bp_addr_adv", busA.imem_addr, 1);
    checkOutput("bp_we_done", busA.imem_we, 0);

    $display("[TB] illegal op");
    pulseClearA();
    applyStimulus(1'b1, 3'd6, 5'd1, 5'd1, 5'd1, 16'h1);
    step();
    applyStimulus(1'b1, 3'd3, 5'd2, 5'd3, 5'd0, 16'h0004);
    #1;
    checkOutput("ill_bad", badA, 1);
    checkOutput("ill_we", busA.imem_we, 0);
    checkOutput("ill_count", countA, 0);
    step();
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    #1;
    checkOutput("ill_sw_wdata", busA.imem_wdata, 32'hAC430004);
    checkOutput("ill_sw_addr", busA.imem_addr, 0);
    step();
    checkOutput("ill_count_after", countA, 1);
    checkOutput("ill_bad_sticky", badA, 1);

    $display("[TB] clear and reset mid-pending");
    busA.imem_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    step();
    applyStimulus(1'b1, 3'd0, 5'd4, 5'd4, 5'd4, 16'h0);
    #1 checkOutput("cm_we", busA.imem_we, 1);
    clearA = 1'b1;
    busA.imem_ready = 1'b1;
    step();
    clearA = 1'b0;
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    #1;
    checkOutput("cm_we_drop", busA.imem_we, 0);
    checkOutput("cm_addr", busA.imem_addr, 0);
    checkOutput("cm_count", countA, 0);
    checkOutput("cm_bad", badA, 0);
    checkOutput("cm_full", fullA, 0);
    checkOutput("cm_rdy", busA.in_ready, 1);
    checkOutput("cm_wdata", busA.imem_wdata, 0);
    busA.imem_ready = 1'b0;
    applyStimulus(1'b1, 3'd2, 5'd4, 5'd5, 5'd0, 16'h0010);
    step();
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0);
    #1 checkOutput("rm_we", busA.imem_we, 1);
    rst = 1'b1;
    #1;
    checkOutput("rm_we_drop", busA.imem_we, 0);
    checkOutput("rm_addr", busA.imem_addr, 0);
    checkOutput("rm_count", countA, 0);
    checkOutput("rm_rdy", busA.in_ready, 1);
    step();
    rst = 1'b0;

    $display("[TB] fill to capacity and address wrap");
    busB.imem_ready = 1'b1;
    busC.imem_ready = 1'b1;
    driveSmall(1'b1, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      driveSmall(1'b1, i + 2);
      #1;
      expWord = 32'h20000000 | (32'(i + 1) << 16) | 32'(i + 1);
      checkOutput($sformatf("fill_we%0d", i), busB.imem_we, 1);
      checkOutput($sformatf("fill_addr%0d", i), busB.imem_addr, 32'(i));
      checkOutput($sformatf("fill_wdata%0d", i), busB.imem_wdata, expWord);
      checkOutput($sformatf("fill_rdy%0d", i), busB.in_ready, (i == 3) ? 32'd0 : 32'd1);
      checkOutput($sformatf("wrap_addr%0d", i), busC.imem_addr, 32'((i + 3) % 4));
      checkOutput($sformatf("wrap_wdata%0d", i), busC.imem_wdata, expWord);
      step();
    end
    checkOutput("fill_full", fullB, 1);
    checkOutput("fill_count", countB, 4);
    checkOutput("fill_we_off", busB.imem_we, 0);
    checkOutput("fill_rdy_off", busB.in_ready, 0);
    checkOutput("wrap_full", fullC, 1);
    checkOutput("wrap_count", countC, 4);
    step();
    step();
    checkOutput("fill_count_hold", countB, 4);
    checkOutput("fill_we_hold", busB.imem_we, 0);
    checkOutput("fill_full_hold", fullB, 1);
    clearB = 1'b1;
    step();
    clearB = 1'b0;
    driveSmall(1'b0, 0);
    #1;
    checkOutput("fill_clr_full", fullB, 0);
    checkOutput("fill_clr_rdy", busB.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
